// File: rtl/tlm_mem_pkg.sv
// rtl/tlm_mem_pkg.sv - shared command, status and FSM state types for the burst memory target
package tlm_mem_pkg;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ADDR_ERR = 2'd1
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_WRESP   = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/tlm_mem_bank.sv
// rtl/tlm_mem_bank.sv - DEPTH x DATA_W memory, byte-enabled write, registered read address (latency 1)
module tlm_mem_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] raddr_q;

    // Contents are deliberately never reset so a reset mid-burst leaves data intact.
    always_ff @(posedge clk_i) begin
        raddr_q <= raddr_i;
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[raddr_q];

endmodule

// File: rtl/tlm_burst_mem_target.sv
// rtl/tlm_burst_mem_target.sv - burst memory target; beat counters enabled by TLM_BURST_MEM_STATS_EN
module tlm_burst_mem_target
    import tlm_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_cmd_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [LEN_W-1:0]      req_len_i,
    input  logic [ID_W-1:0]       req_id_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [1:0]            rsp_status_o,
    output logic                  rsp_last_o,
    output logic                  busy_o,
    output logic [31:0]           rd_beats_o,
    output logic [31:0]           wr_beats_o
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [ID_W-1:0]     rsp_id_q;
    status_e             rsp_status_q;
    logic                req_ready_q;
    logic                wdata_ready_q;
    logic                rsp_valid_q;
    logic                rsp_last_q;
    logic                busy_q;

    logic [ADDR_W:0]     end_addr;
    logic                req_err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_we;
    logic                wr_hs;
    logic                rd_hs;

    // One extra bit so a burst running past the top of memory is caught instead of wrapping.
    assign end_addr = {1'b0, req_addr_i} + (ADDR_W+1)'(req_len_i);
    assign req_err  = end_addr > LAST_ADDR;
    assign mem_addr = addr_q + ADDR_W'(beat_q);
    assign wr_hs    = (state_q == S_WRITE) && wdata_valid_i;
    assign rd_hs    = (state_q == S_RD_DATA) && rsp_ready_i;
    assign mem_we   = wr_hs && (rsp_status_q == ST_OK);

    tlm_mem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_addr),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            rsp_id_q      <= '0;
            rsp_status_q  <= ST_OK;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q       <= req_addr_i;
                        len_q        <= req_len_i;
                        beat_q       <= '0;
                        rsp_id_q     <= req_id_i;
                        rsp_status_q <= req_err ? ST_ADDR_ERR : ST_OK;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        if (cmd_e'(req_cmd_i) == CMD_WRITE) begin
                            state_q       <= S_WRITE;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RD_ADDR;
                        end
                    end
                end
                S_WRITE: begin
                    if (wdata_valid_i) begin
                        if (beat_q == len_q) begin
                            state_q       <= S_WRESP;
                            wdata_ready_q <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_last_q    <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_WRESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                S_RD_ADDR: begin
                    state_q     <= S_RD_DATA;
                    rsp_valid_q <= 1'b1;
                    rsp_last_q  <= (beat_q == len_q);
                end
                S_RD_DATA: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        if (beat_q == len_q) begin
                            state_q     <= S_IDLE;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= S_RD_ADDR;
                            beat_q  <= beat_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_last_o    = rsp_last_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_status_o  = rsp_status_q;
    assign busy_o        = busy_q;
    // Erroring reads return zero; the bank output is simply ignored for them.
    assign rsp_data_o    = (state_q == S_RD_DATA && rsp_status_q == ST_OK) ? mem_rdata : '0;

`ifdef TLM_BURST_MEM_STATS_EN
    logic [31:0] rd_beats_q;
    logic [31:0] wr_beats_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_beats_q <= '0;
            wr_beats_q <= '0;
        end else begin
            if (rd_hs) rd_beats_q <= rd_beats_q + 32'd1;
            if (wr_hs) wr_beats_q <= wr_beats_q + 32'd1;
        end
    end

    assign rd_beats_o = rd_beats_q;
    assign wr_beats_o = wr_beats_q;
`else
    logic unused_hs;
    assign unused_hs  = rd_hs ^ wr_hs;
    assign rd_beats_o = '0;
    assign wr_beats_o = '0;
`endif

endmodule

// File: tb/tb_tlm_burst_mem_target.sv
// tb/tb_tlm_burst_mem_target.sv - scoreboard bench for tlm_burst_mem_target
module tb_tlm_burst_mem_target;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_cmd_i = 1'b0;
    logic [7:0]  req_addr_i = '0;
    logic [3:0]  req_len_i = '0;
    logic [3:0]  req_id_i = '0;
    logic        wdata_valid_i = 1'b0;
    logic        wdata_ready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_data_o;
    logic [3:0]  rsp_id_o;
    logic [1:0]  rsp_status_o;
    logic        rsp_last_o;
    logic        busy_o;
    logic [31:0] rd_beats_o;
    logic [31:0] wr_beats_o;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  st;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          errors = 0;
    int          checks = 0;

`ifdef TLM_BURST_MEM_STATS_EN
    localparam logic [31:0] EXP_WR = 32'd2;
    localparam logic [31:0] EXP_RD = 32'd3;
`else
    localparam logic [31:0] EXP_WR = 32'd0;
    localparam logic [31:0] EXP_RD = 32'd0;
`endif

    always #5 clk = ~clk;

    tlm_burst_mem_target dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_cmd_i     (req_cmd_i),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
        .req_id_i      (req_id_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wdata_i       (wdata_i),
        .wstrb_i       (wstrb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_id_o      (rsp_id_o),
        .rsp_status_o  (rsp_status_o),
        .rsp_last_o    (rsp_last_o),
        .busy_o        (busy_o),
        .rd_beats_o    (rd_beats_o),
        .wr_beats_o    (wr_beats_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", rsp_data_o, e.data);
                chk("rsp_id", rsp_id_o, e.id);
                chk("rsp_status", rsp_status_o, e.st);
                chk("rsp_last", rsp_last_o, e.last);
            end
        end
    end

    function automatic logic is_err(input logic [7:0] a, input logic [3:0] l);
        return ({1'b0, a} + 9'(l)) > 9'd255;
    endfunction

    task automatic send_req(input logic c, input logic [7:0] a, input logic [3:0] l, input logic [3:0] id);
        logic ok;
        int   n;
        req_valid_i = 1'b1; req_cmd_i = c; req_addr_i = a; req_len_i = l; req_id_i = id;
        n = 0;
        do begin
            ok = req_ready_o;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("req_timeout", 0, 1);
        req_valid_i = 1'b0;
    endtask

    task automatic write_beat(input logic [31:0] d, input logic [3:0] s, input logic [7:0] a, input logic err);
        logic ok;
        int   n;
        wdata_valid_i = 1'b1; wdata_i = d; wstrb_i = s;
        n = 0;
        do begin
            ok = wdata_ready_o;
            tick();
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("wbeat_timeout", 0, 1);
        wdata_valid_i = 1'b0;
        if (ok && !err)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || sb.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (busy_o || sb.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rsp_valid_o && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid_o) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id,
                            input logic [31:0] base, input logic [3:0] s);
        logic err;
        exp_t e;
        err = is_err(a, l);
        e.data = '0; e.id = id; e.st = err ? 2'd1 : 2'd0; e.last = 1'b1;
        sb.push_back(e);
        send_req(1'b1, a, l, id);
        for (int i = 0; i <= int'(l); i++) write_beat(base + 32'(i), s, a + 8'(i), err);
        wait_idle();
    endtask

    task automatic push_read(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id, input int nbeats);
        logic err;
        exp_t e;
        err = is_err(a, l);
        for (int i = 0; i < nbeats; i++) begin
            e.data = err ? 32'd0 : model[a + 8'(i)];
            e.id = id; e.st = err ? 2'd1 : 2'd0; e.last = (i == int'(l));
            sb.push_back(e);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] l, input logic [3:0] id, input logic lat);
        push_read(a, l, id, int'(l) + 1);
        send_req(1'b0, a, l, id);
        if (lat) begin
            chk("rd_lat_accept_plus1", rsp_valid_o, 0);
            tick();
            chk("rd_lat_accept_plus2", rsp_valid_o, 1);
        end
        wait_idle();
    endtask

    initial begin
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_wdata_ready", wdata_ready_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_rsp_id", rsp_id_o, 0);
        chk("rst_rsp_status", rsp_status_o, 0);
        chk("rst_rsp_last", rsp_last_o, 0);
        chk("rst_rd_beats", rd_beats_o, 0);
        chk("rst_wr_beats", wr_beats_o, 0);

        do_write(8'h10, 4'd0, 4'd1, 32'hDEADBEEF, 4'hF);
        do_read(8'h10, 4'd0, 4'd1, 1'b1);

        do_write(8'h20, 4'd0, 4'd2, 32'h11223344, 4'hF);
        do_write(8'h20, 4'd0, 4'd2, 32'hAABBCCDD, 4'h3);
        chk("merge_model", model[8'h20], 32'h1122CCDD);
        do_read(8'h20, 4'd0, 4'd2, 1'b0);

        // wdata offered while idle must be dropped
        wdata_valid_i = 1'b1; wdata_i = 32'h0BADF00D; wstrb_i = 4'hF;
        tick(); tick(); tick();
        chk("idle_wdata_busy", busy_o, 0);
        chk("idle_wdata_ready", wdata_ready_o, 0);
        wdata_valid_i = 1'b0;
        do_read(8'h10, 4'd0, 4'd3, 1'b0);

        // four-beat burst, reader stalls three cycles on beat 1
        do_write(8'h40, 4'd3, 4'd5, 32'd1, 4'hF);
        push_read(8'h40, 4'd3, 4'd5, 4);
        rsp_ready_i = 1'b1;
        send_req(1'b0, 8'h40, 4'd3, 4'd5);
        tick(); tick();
        rsp_ready_i = 1'b0;
        wait_valid();
        for (int k = 0; k < 3; k++) begin
            chk("stall_data", rsp_data_o, 32'd2);
            chk("stall_last", rsp_last_o, 0);
            chk("stall_valid", rsp_valid_o, 1);
            tick();
        end
        rsp_ready_i = 1'b1;
        wait_idle();

        // out-of-range bursts
        do_write(8'hFE, 4'd1, 4'd6, 32'hCAFE0000, 4'hF);
        do_read(8'hFE, 4'd3, 4'd6, 1'b0);
        do_write(8'hFE, 4'd3, 4'd7, 32'h55550000, 4'hF);
        chk("err_wr_fe", model[8'hFE], 32'hCAFE0000);
        do_read(8'hFE, 4'd1, 4'd7, 1'b0);
        do_write(8'hFF, 4'd0, 4'd8, 32'h0000FFFF, 4'hF);
        do_read(8'hFF, 4'd0, 4'd8, 1'b0);

        // reset after beat 1 of a four-beat read
        push_read(8'h40, 4'd3, 4'd9, 2);
        send_req(1'b0, 8'h40, 4'd3, 4'd9);
        tick(); tick(); tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_valid", rsp_valid_o, 0);
        chk("midrst_req_ready", req_ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        tick(); tick(); tick();
        chk("midrst_quiet", rsp_valid_o, 0);
        chk("midrst_sb_drained", sb.size(), 0);
        do_read(8'h40, 4'd3, 4'd9, 1'b0);

        // beat counters after a fresh reset
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        do_write(8'h50, 4'd1, 4'd2, 32'h70, 4'hF);
        do_read(8'h50, 4'd2, 4'd2, 1'b0);
        chk("wr_beats", wr_beats_o, EXP_WR);
        chk("rd_beats", rd_beats_o, EXP_RD);

        do_write(8'h80, 4'd15, 4'd4, 32'h1000, 4'hF);
        for (int r = 0; r < 8; r++) begin
            logic [7:0]  a;
            logic [3:0]  l;
            logic [3:0]  s;
            a = 8'h80 + 8'($urandom_range(0, 12));
            l = 4'($urandom_range(0, 3));
            s = 4'($urandom_range(1, 15));
            do_write(a, l, 4'(r), $urandom, s);
            do_read(a, l, 4'(r), 1'b0);
        end

        chk("sb_empty_end", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlm_burst_mem_target.md
TLM_BURST_MEM_TARGET -- requirements
Module: tlm_burst_mem_target

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8, word address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width (beats = len+1).
REQ-004 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-005 SHALL have ports: clk_i  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: req_valid_i in 1; req_ready_o out 1; req_cmd_i in 1 (0=READ, 1=WRITE); req_addr_i in ADDR_W; req_len_i in LEN_W; req_id_i in ID_W.
REQ-008 SHALL have ports: wdata_valid_i in 1; wdata_ready_o out 1; wdata_i in DATA_W; wstrb_i in DATA_W/8, byte enables.
REQ-009 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_data_o out DATA_W; rsp_id_o out ID_W; rsp_status_o out 2 (0=OK, 1=ADDR_ERR); rsp_last_o out 1.
REQ-010 SHALL have ports: busy_o out 1 (state != IDLE); rd_beats_o out 32; wr_beats_o out 32.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, WRESP, RD_ADDR, RD_DATA.
REQ-012 req_ready_o SHALL be 1 only in IDLE; a request is accepted on req_valid_i && req_ready_o, latching cmd, addr, len, id and beat counter = 0.
REQ-013 Accepted WRITE SHALL go to WRITE; accepted READ SHALL go to RD_ADDR.
REQ-014 Request SHALL be flagged ADDR_ERR when req_addr_i + req_len_i > DEPTH-1 (computed ADDR_W+1 bits wide, no wrap); otherwise OK.
REQ-015 In WRITE, wdata_ready_o SHALL be 1; each wdata handshake SHALL write byte lanes with wstrb_i=1 to word addr+beat, visible to reads from the next cycle; lanes with strobe 0 unchanged.
REQ-016 ADDR_ERR write SHALL consume all len+1 beats without modifying memory.
REQ-017 After beat len handshake, FSM SHALL go to WRESP: rsp_valid_o=1, rsp_last_o=1, rsp_data_o=0, rsp_id_o=latched id, rsp_status_o=latched status, held until rsp_ready_i, then IDLE.
REQ-018 RD_ADDR SHALL present addr+beat to memory for one cycle then go to RD_DATA; data SHALL appear on rsp_data_o in RD_DATA (first rsp_valid_o two cycles after request accept).
REQ-019 In RD_DATA, rsp_valid_o=1, rsp_id_o, rsp_status_o held stable with rsp_data_o until rsp_ready_i; rsp_last_o=1 only on beat len.
REQ-020 On RD_DATA handshake: if beat==len go to IDLE, else beat+1 and RD_ADDR (one idle cycle between read beats).
REQ-021 ADDR_ERR read SHALL return len+1 beats with rsp_data_o=0, status ADDR_ERR, memory not accessed.
REQ-022 req_valid_i in non-IDLE states SHALL be ignored (not accepted); wdata_valid_i outside WRITE SHALL be ignored.
REQ-023 rd_beats_o / wr_beats_o SHALL increment by 1 per completed read-response / write-data handshake, OK and ADDR_ERR alike, wrapping modulo 2**32.

Reset
REQ-024 rst_i high at a rising edge SHALL force IDLE, beat counter 0, rsp_valid_o=0, rsp_last_o=0, rsp_data_o=0, rsp_id_o=0, rsp_status_o=0, wdata_ready_o=0, busy_o=0, req_ready_o=1 next cycle, counters 0.
REQ-025 Reset mid-burst SHALL abandon the transaction with no further responses; memory contents SHALL NOT be reset or modified.

Configuration
REQ-026 With TLM_BURST_MEM_STATS_EN defined, rd_beats_o/wr_beats_o SHALL count per REQ-023; without it both SHALL be constant 0 and no counter flops synthesized.

Structure
REQ-027 Shared package tlm_mem_pkg SHALL hold cmd enum (READ, WRITE), status enum (OK, ADDR_ERR) and FSM state enum.
REQ-028 Memory SHALL be sub-module tlm_mem_bank: DEPTH x DATA_W, byte-enabled synchronous write, registered read address, read latency 1.

Verification
REQ-029 WRITE addr=0x10 len=0 data=0xDEADBEEF strb=0xF, then READ addr=0x10 len=0 -> WRESP OK; read beat 0xDEADBEEF, last=1, OK.
REQ-030 WRITE addr=0x20 strb=0xF data=0x11223344, then WRITE strb=0x3 data=0xAABBCCDD, READ -> 0x1122CCDD.
REQ-031 WRITE addr=0x40 len=3 data 1,2,3,4 id=5; READ len=3 with rsp_ready_i low 3 cycles on beat 1 -> beats 1,2,3,4, id=5, last only on 4th, data stable while stalled.
REQ-032 READ addr=0xFE len=3 (DEPTH=256) -> 4 beats data 0 status ADDR_ERR; WRITE same range leaves words 0xFE,0xFF unchanged.
REQ-033 rst_i asserted after beat 1 of a len=3 read -> rsp_valid_o=0 next cycle, req_ready_o=1, prior memory contents intact.
REQ-034 With TLM_BURST_MEM_STATS_EN, 2 write beats + 3 read beats -> wr_beats_o=2, rd_beats_o=3; without macro both 0.
